// File: rtl/mmu_psum_collector_if.sv
// +--------------------------------------------------------------------------+
// | mmu_psum_collector_if : skewed psum input and row valid/ready output bus |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface mmu_psum_collector_if #(
    parameter int NUM_COL    = 4,
    parameter int PSUM_WIDTH = 32
) ();
    logic [NUM_COL*PSUM_WIDTH-1:0] psum_i;
    logic [NUM_COL-1:0]            psum_en_i;
    logic [NUM_COL*PSUM_WIDTH-1:0] out_data_o;
    logic                          out_valid_o;
    logic                          out_ready_i;

    // Driver side: MMU bottom row plus the downstream ready.
    modport master (
        output psum_i, psum_en_i, out_ready_i,
        input  out_data_o, out_valid_o
    );

    // Collector side.
    modport slave (
        input  psum_i, psum_en_i, out_ready_i,
        output out_data_o, out_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/mmu_psum_collector.sv
// +--------------------------------------------------------------------------+
// | mmu_psum_collector : deskews staggered MMU psum columns into rows, FIFO  |
// | buffers them and flags overflow/skew. Option: MMU_COLLECT_RELU_EN clamps |
// | negative elements to zero on the read side. Revision 1.0                 |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mmu_psum_collector #(
    parameter int NUM_COL    = 4,
    parameter int PSUM_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    mmu_psum_collector_if.slave              bus,
    input  wire logic                        clr_i,
    output logic                             ovf_o,
    output logic                             skew_err_o,
    output logic [CNT_WIDTH-1:0]             row_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_cnt_o
);

    localparam int                 AW        = $clog2(FIFO_DEPTH);
    localparam int                 ROW_W     = NUM_COL*PSUM_WIDTH;
    localparam logic [AW:0]        OCC_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]        OCC_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]      PTR_ONE   = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [ROW_W-1:0]   aligned_data;
    logic [NUM_COL-1:0] aligned_en;

    // Column c needs NUM_COL-1-c stages so every column lines up with the last one.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        localparam int DEPTH = NUM_COL - 1 - c;
        if (DEPTH == 0) begin : g_pass
            assign aligned_data[c*PSUM_WIDTH +: PSUM_WIDTH] = bus.psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
            assign aligned_en[c]                            = bus.psum_en_i[c];
        end else begin : g_dly
            logic [PSUM_WIDTH:0] stage [DEPTH];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= {bus.psum_en_i[c], bus.psum_i[c*PSUM_WIDTH +: PSUM_WIDTH]};
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end
            assign aligned_en[c]                            = stage[DEPTH-1][PSUM_WIDTH];
            assign aligned_data[c*PSUM_WIDTH +: PSUM_WIDTH] = stage[DEPTH-1][PSUM_WIDTH-1:0];
        end
    end

    logic [ROW_W-1:0]   row_data;
    logic [NUM_COL-1:0] row_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data <= '0;
            row_en   <= '0;
        end else begin
            row_data <= aligned_data;
            row_en   <= aligned_en;
        end
    end

    logic             row_vld;
    logic             row_mixed;
    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             ovf;
    logic             skew_err;
    logic [CNT_WIDTH-1:0] row_cnt;

    assign row_vld   = &row_en;
    assign row_mixed = (|row_en) & ~row_vld;
    assign empty     = (occ == '0);
    assign full      = (occ == OCC_FULL);
    assign pop       = ~empty & bus.out_ready_i;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign push      = row_vld & (~full | pop);
    assign drop      = row_vld & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= row_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            skew_err <= 1'b0;
            row_cnt  <= '0;
        end else if (clr_i) begin
            ovf      <= 1'b0;
            skew_err <= 1'b0;
            row_cnt  <= '0;
        end else begin
            if (drop)      ovf      <= 1'b1;
            if (row_mixed) skew_err <= 1'b1;
            if (push)      row_cnt  <= row_cnt + CNT_ONE;
        end
    end

    logic [ROW_W-1:0] head;
    assign head = mem[rd_ptr];

    // Gated by empty so the unreset storage never leaks onto the output.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_out
        logic [PSUM_WIDTH-1:0] elem;
        assign elem = head[c*PSUM_WIDTH +: PSUM_WIDTH];
`ifdef MMU_COLLECT_RELU_EN
        assign bus.out_data_o[c*PSUM_WIDTH +: PSUM_WIDTH] =
            (empty | elem[PSUM_WIDTH-1]) ? '0 : elem;
`else
        assign bus.out_data_o[c*PSUM_WIDTH +: PSUM_WIDTH] = empty ? '0 : elem;
`endif
    end

    assign bus.out_valid_o = ~empty;
    assign ovf_o           = ovf;
    assign skew_err_o      = skew_err;
    assign row_cnt_o       = row_cnt;
    assign fifo_cnt_o      = occ;

endmodule

`default_nettype wire

// File: tb/tb_mmu_psum_collector.sv
// +--------------------------------------------------------------------------+
// | tb_mmu_psum_collector : randomized self-checking bench with a row-level  |
// | reference model. Revision 1.0                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mmu_psum_collector;

    localparam int NC  = 4;
    localparam int PW  = 32;
    localparam int FD  = 8;
    localparam int CW  = 4;
    localparam int FCW = $clog2(FD) + 1;
    localparam int SW  = FCW + CW + 3;

    typedef logic [NC*PW-1:0] row_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_i = 1'b0;
    logic            ovf_o;
    logic            skew_err_o;
    logic [CW-1:0]   row_cnt_o;
    logic [FCW-1:0]  fifo_cnt_o;

    mmu_psum_collector_if #(.NUM_COL(NC), .PSUM_WIDTH(PW)) bus ();

    mmu_psum_collector #(
        .NUM_COL(NC), .PSUM_WIDTH(PW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .clr_i      (clr_i),
        .ovf_o      (ovf_o),
        .skew_err_o (skew_err_o),
        .row_cnt_o  (row_cnt_o),
        .fifo_cnt_o (fifo_cnt_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: a row is the set of column inputs at edges s, s+1, ..., s+NC-1;
    // it resolves at edge s+NC into a push, a drop or a skew error.
    row_t          mq[$];
    logic          m_ovf;
    logic          m_skew;
    logic [CW-1:0] m_cnt;
    logic [NC-1:0] hist_en [16];
    row_t          hist_d  [16];
    int            edge_n = 0;
    bit            in_reset = 1'b0;
    row_t          sent[$];

    function automatic row_t relu_view(row_t r);
        row_t o = r;
`ifdef MMU_COLLECT_RELU_EN
        for (int c = 0; c < NC; c++) if (r[c*PW+PW-1]) o[c*PW +: PW] = '0;
`endif
        return o;
    endfunction

    function automatic row_t exp_data();
        if (mq.size() == 0) return '0;
        return relu_view(mq[0]);
    endfunction

    function automatic logic [SW-1:0] exp_status();
        return {mq.size() != 0, FCW'(mq.size()), m_ovf, m_skew, m_cnt};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_skew = 1'b0;
        m_cnt  = '0;
        for (int i = 0; i < 16; i++) begin
            hist_en[i] = '0;
            hist_d[i]  = '0;
        end
    endtask

    task automatic drive_cycle(input logic [NC-1:0] en, input row_t data,
                               input logic rdy, input logic clr);
        logic [NC-1:0] ae;
        row_t          ar;
        int            idx;
        bus.psum_en_i   = en;
        bus.psum_i      = data;
        bus.out_ready_i = rdy;
        clr_i           = clr;
        if (in_reset) begin
            hist_en[edge_n % 16] = '0;
            hist_d[edge_n % 16]  = '0;
        end else begin
            hist_en[edge_n % 16] = en;
            hist_d[edge_n % 16]  = data;
            ae = '0;
            ar = '0;
            if (edge_n >= NC) begin
                for (int c = 0; c < NC; c++) begin
                    idx = (edge_n - NC + c) % 16;
                    ae[c] = hist_en[idx][c];
                    ar[c*PW +: PW] = hist_d[idx][c*PW +: PW];
                end
            end
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (&ae) begin
                if (mq.size() < FD) begin
                    mq.push_back(ar);
                    m_cnt = m_cnt + CW'(1);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (|ae) begin
                m_skew = 1'b1;
            end
            if (clr) begin
                m_ovf  = 1'b0;
                m_skew = 1'b0;
                m_cnt  = '0;
            end
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Sends nrows back-to-back staggered rows; skip_col>=0 suppresses that column.
    task automatic play(input int nrows, input int rdy_mode, input int skip_col);
        row_t          rows[$];
        row_t          r;
        row_t          d;
        logic [NC-1:0] en;
        logic          rdy;
        int            ri;
        for (int i = 0; i < nrows; i++) begin
            for (int c = 0; c < NC; c++) r[c*PW +: PW] = $urandom();
            rows.push_back(r);
            sent.push_back(r);
        end
        for (int k = 0; k < nrows + NC + 1; k++) begin
            en = '0;
            d  = '0;
            for (int c = 0; c < NC; c++) begin
                ri = k - c;
                if (ri >= 0 && ri < nrows && c != skip_col) begin
                    en[c] = 1'b1;
                    d[c*PW +: PW] = rows[ri][c*PW +: PW];
                end
            end
            rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
            drive_cycle(en, d, rdy, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_clear();
        repeat (3) drive_cycle('0, '0, 1'b0, 1'b0);
        tests_run++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
        tests_run++; if (bus.out_data_o !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.out_data_o); end
        tests_run++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        tests_run++; if (skew_err_o !== 1'b0) begin fails++; $display("FAIL reset_skew: got %b want 0", skew_err_o); end
        tests_run++; if (row_cnt_o !== '0) begin fails++; $display("FAIL reset_row_cnt: got %0d want 0", row_cnt_o); end
        tests_run++; if (fifo_cnt_o !== '0) begin fails++; $display("FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt_o); end
        rst_n    = 1'b1;
        in_reset = 1'b0;
        repeat (2) drive_cycle('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_single_row();
        row_t d;
        row_t want;
        want = '0;
        for (int c = 0; c < NC; c++) want[c*PW +: PW] = PW'(c + 1);
        for (int k = 0; k <= NC; k++) begin
            d = '0;
            if (k < NC) d[k*PW +: PW] = PW'(k + 1);
            drive_cycle((k < NC) ? NC'(1 << k) : '0, d, 1'b0, 1'b0);
            tests_run++;
            if (bus.out_valid_o !== (k == NC)) begin
                fails++; $display("FAIL single_latency k=%0d: got %b want %b", k, bus.out_valid_o, (k == NC));
            end
        end
        tests_run++; if (bus.out_data_o !== want) begin fails++; $display("FAIL single_data: got %h want %h", bus.out_data_o, want); end
        tests_run++; if (row_cnt_o !== CW'(1)) begin fails++; $display("FAIL single_row_cnt: got %0d want 1", row_cnt_o); end
        tests_run++; if (fifo_cnt_o !== FCW'(1)) begin fails++; $display("FAIL single_fifo_cnt: got %0d want 1", fifo_cnt_o); end
        drive_cycle('0, '0, 1'b1, 1'b0);
        tests_run++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_overflow();
        sent.delete();
        drive_cycle('0, '0, 1'b0, 1'b1);
        play(8, 0, -1);
        tests_run++; if (fifo_cnt_o !== FCW'(8)) begin fails++; $display("FAIL ovf_fill_cnt: got %0d want 8", fifo_cnt_o); end
        tests_run++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL ovf_fill_flag: got %b want 0", ovf_o); end
        play(1, 0, -1);
        tests_run++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovf_o); end
        tests_run++; if (row_cnt_o !== CW'(8)) begin fails++; $display("FAIL ovf_row_cnt: got %0d want 8", row_cnt_o); end
        tests_run++; if (fifo_cnt_o !== FCW'(8)) begin fails++; $display("FAIL ovf_fifo_cnt: got %0d want 8", fifo_cnt_o); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== relu_view(sent[i])) begin
                fails++; $display("FAIL ovf_drain[%0d]: got %b/%h want 1/%h", i, bus.out_valid_o, bus.out_data_o, relu_view(sent[i]));
            end
            drive_cycle('0, '0, 1'b1, 1'b0);
        end
        tests_run++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL ovf_ninth_absent: got %b want 0", bus.out_valid_o); end
    endtask

    task automatic test_full_with_pop();
        row_t r;
        row_t d;
        sent.delete();
        drive_cycle('0, '0, 1'b0, 1'b1);
        play(8, 0, -1);
        for (int c = 0; c < NC; c++) r[c*PW +: PW] = $urandom();
        sent.push_back(r);
        for (int k = 0; k <= NC; k++) begin
            d = '0;
            if (k < NC) d[k*PW +: PW] = r[k*PW +: PW];
            drive_cycle((k < NC) ? NC'(1 << k) : '0, d, (k == NC), 1'b0);
        end
        tests_run++; if (fifo_cnt_o !== FCW'(8)) begin fails++; $display("FAIL fullpop_cnt: got %0d want 8", fifo_cnt_o); end
        tests_run++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL fullpop_ovf: got %b want 0", ovf_o); end
        tests_run++; if (row_cnt_o !== CW'(9)) begin fails++; $display("FAIL fullpop_row_cnt: got %0d want 9", row_cnt_o); end
        for (int i = 1; i <= 8; i++) begin
            tests_run++;
            if (bus.out_data_o !== relu_view(sent[i])) begin
                fails++; $display("FAIL fullpop_order[%0d]: got %h want %h", i, bus.out_data_o, relu_view(sent[i]));
            end
            drive_cycle('0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_skew_clear();
        row_t d;
        play(1, 0, 2);
        tests_run++; if (skew_err_o !== 1'b1) begin fails++; $display("FAIL skew_flag: got %b want 1", skew_err_o); end
        tests_run++; if (fifo_cnt_o !== FCW'(0)) begin fails++; $display("FAIL skew_no_push: got %0d want 0", fifo_cnt_o); end
        tests_run++; if (row_cnt_o !== CW'(9)) begin fails++; $display("FAIL skew_row_cnt: got %0d want 9", row_cnt_o); end
        drive_cycle('0, '0, 1'b0, 1'b1);
        tests_run++; if (skew_err_o !== 1'b0) begin fails++; $display("FAIL clr_skew: got %b want 0", skew_err_o); end
        tests_run++; if (row_cnt_o !== CW'(0)) begin fails++; $display("FAIL clr_row_cnt: got %0d want 0", row_cnt_o); end
        // Clear coinciding with a push: the row lands but the counter reads 0.
        for (int k = 0; k <= NC; k++) begin
            d = '0;
            if (k < NC) d[k*PW +: PW] = $urandom();
            drive_cycle((k < NC) ? NC'(1 << k) : '0, d, 1'b0, (k == NC));
        end
        tests_run++; if (row_cnt_o !== CW'(0)) begin fails++; $display("FAIL clr_push_row_cnt: got %0d want 0", row_cnt_o); end
        tests_run++; if (fifo_cnt_o !== FCW'(1)) begin fails++; $display("FAIL clr_push_fifo: got %0d want 1", fifo_cnt_o); end
        drive_cycle('0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_row();
        row_t d;
        play(1, 0, -1);
        for (int k = 0; k < 2; k++) begin
            d = '0;
            d[k*PW +: PW] = $urandom();
            drive_cycle(NC'(1 << k), d, 1'b0, 1'b0);
        end
        #3;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_clear();
        #1;
        tests_run++;
        if ({bus.out_valid_o, fifo_cnt_o, row_cnt_o} !== '0 || bus.out_data_o !== '0) begin
            fails++; $display("FAIL midrst_async: got v=%b cnt=%0d rows=%0d data=%h want all 0",
                              bus.out_valid_o, fifo_cnt_o, row_cnt_o, bus.out_data_o);
        end
        d = '0; d[2*PW +: PW] = $urandom();
        drive_cycle(NC'(4), d, 1'b0, 1'b0);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        d = '0; d[3*PW +: PW] = $urandom();
        drive_cycle(NC'(8), d, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive_cycle('0, '0, 1'b0, 1'b0);
            tests_run++;
            if ({bus.out_valid_o, fifo_cnt_o} !== '0) begin
                fails++; $display("FAIL midrst_phantom[%0d]: got v=%b cnt=%0d want 0/0", k, bus.out_valid_o, fifo_cnt_o);
            end
        end
    endtask

    task automatic test_relu();
        row_t r;
        row_t d;
        row_t want;
        r = {32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'd3};
`ifdef MMU_COLLECT_RELU_EN
        want = {32'd0, 32'd7, 32'd0, 32'd3};
`else
        want = r;
`endif
        for (int k = 0; k <= NC; k++) begin
            d = '0;
            if (k < NC) d[k*PW +: PW] = r[k*PW +: PW];
            drive_cycle((k < NC) ? NC'(1 << k) : '0, d, 1'b0, 1'b0);
        end
        tests_run++; if (bus.out_data_o !== want) begin fails++; $display("FAIL relu_row: got %h want %h", bus.out_data_o, want); end
        drive_cycle('0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_cycle('0, '0, 1'b0, 1'b1);
        play(20, 1, -1);
        tests_run++; if (row_cnt_o !== CW'(20 % 16)) begin fails++; $display("FAIL b2b_row_cnt_wrap: got %0d want %0d", row_cnt_o, 20 % 16); end
        tests_run++; if ({ovf_o, fifo_cnt_o} !== '0) begin fails++; $display("FAIL b2b_drained: got ovf=%b cnt=%0d want 0/0", ovf_o, fifo_cnt_o); end
    endtask

    task automatic test_random();
        localparam int NR = 300;
        row_t          rr   [NR];
        bit            on   [NR];
        int            miss [NR];
        row_t          d;
        logic [NC-1:0] en;
        logic          rdy;
        logic          clr;
        int            ri;
        for (int i = 0; i < NR; i++) begin
            for (int c = 0; c < NC; c++) rr[i][c*PW +: PW] = $urandom();
            on[i]   = ($urandom_range(0, 3) != 0);
            miss[i] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, NC-1)) : -1;
        end
        for (int k = 0; k < NR + NC + 20; k++) begin
            en = '0;
            d  = '0;
            for (int c = 0; c < NC; c++) begin
                ri = k - c;
                if (ri >= 0 && ri < NR && on[ri] && miss[ri] != c) begin
                    en[c] = 1'b1;
                    d[c*PW +: PW] = rr[ri][c*PW +: PW];
                end
            end
            if (k >= NR) rdy = 1'b1;
            else if ((k / 40) % 2 == 0) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            drive_cycle(en, d, rdy, clr);
            tests_run++;
            if ({bus.out_valid_o, fifo_cnt_o, ovf_o, skew_err_o, row_cnt_o} !== exp_status()) begin
                fails++; $display("FAIL rand_status[%0d]: got %h want %h", k,
                                  {bus.out_valid_o, fifo_cnt_o, ovf_o, skew_err_o, row_cnt_o}, exp_status());
            end
            tests_run++;
            if (bus.out_data_o !== exp_data()) begin
                fails++; $display("FAIL rand_data[%0d]: got %h want %h", k, bus.out_data_o, exp_data());
            end
        end
    endtask

    initial begin
        bus.psum_i      = '0;
        bus.psum_en_i   = '0;
        bus.out_ready_i = 1'b0;
        model_clear();
        test_reset();
        test_single_row();
        test_overflow();
        test_full_with_pop();
        test_skew_clear();
        test_reset_mid_row();
        test_relu();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
